dtc_share_ctrl: RTL and testbench



---
 rtl/dtc_ctrl_pkg.sv | 28 ++
 rtl/dtc_share_ctrl_if.sv | 40 ++++
 rtl/dtc_rr_arbiter.sv | 47 ++++
 rtl/dtc_share_ctrl.sv | 127 ++++++++++++
 tb/tb_dtc_share_ctrl.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dtc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dtc_ctrl_pkg
// Purpose : Shared types and helpers for the decision-tree-classifier share
//           controller. Provides the sequencer state encoding and the
//           requester-ID width function.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package dtc_ctrl_pkg;

  // Sequencer states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // Width of an index into n items, never narrower than one bit so that a
  // single-requester build still has a legal ID/pointer field.
  function automatic int id_width(input int n);
    int w;
    w = (n > 1) ? $clog2(n) : 1;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dtc_share_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : dtc_share_ctrl_if
// Purpose : Request/response bus between feature producers and the shared
//           classifier controller.
// Ports   : req_valid/req_ready/req_feat - N_REQ request channels
//           rsp_valid/rsp_ready/rsp_id/rsp_cls - single response channel
//           modport master: producer/consumer side
//           modport slave : controller side
// Revision: 1.0 - initial release
// ============================================================================
interface dtc_share_ctrl_if
  import dtc_ctrl_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int FEAT_W = 8,
  parameter int CLS_W  = 7
);
  localparam int ID_W = id_width(N_REQ);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*FEAT_W-1:0] req_feat;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [ID_W-1:0]         rsp_id;
  logic [CLS_W-1:0]        rsp_cls;

  modport master (
    output req_valid, req_feat, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_cls
  );

  modport slave (
    input  req_valid, req_feat, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_cls
  );

endinterface
`default_nettype wire

// File: rtl/dtc_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : dtc_rr_arbiter
// Purpose : Combinational round-robin picker. Selects the first set bit of
//           valid searching from ptr upward and wrapping modulo N_REQ.
// Ports   : valid     in  N_REQ  request vector
//           ptr       in  ID_W   highest-priority index this cycle
//           grant     out N_REQ  one-hot grant (zero when nothing valid)
//           grant_idx out ID_W   index of the granted bit
//           any_valid out 1      valid is nonzero
// Revision: 1.0 - initial release
// ============================================================================
module dtc_rr_arbiter
  import dtc_ctrl_pkg::*;
#(
  parameter int N_REQ = 4
)(
  input  logic [N_REQ-1:0]           valid,
  input  logic [id_width(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]           grant,
  output logic [id_width(N_REQ)-1:0] grant_idx,
  output logic                       any_valid
);
  localparam int ID_W = id_width(N_REQ);

  always_comb begin
    int   idx;
    logic found;
    idx       = 0;
    found     = 1'b0;
    grant     = '0;
    grant_idx = '0;
    // ptr is always < N_REQ, so a single conditional subtract wraps it.
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = ID_W'(idx);
      end
    end
    any_valid = found;
  end

endmodule
`default_nettype wire

// File: rtl/dtc_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : dtc_share_ctrl
// Purpose : Lets N_REQ requesters share one combinational decision-tree
//           classifier. A round-robin winner's feature vector is registered
//           onto core_feat, held EVAL_CYC cycles, then core_cls is captured
//           and returned on the response channel tagged with the winner ID.
// Ports   : clk       in  1       rising-edge clock
//           rst_n     in  1       asynchronous active-low reset
//           bus       slave       request/response channels
//           core_feat out FEAT_W  registered vector to the classifier
//           core_cls  in  CLS_W   classifier result
//           busy      out 1       high whenever not idle
// Revision: 1.0 - initial release
// ============================================================================
module dtc_share_ctrl
  import dtc_ctrl_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int FEAT_W   = 8,
  parameter int CLS_W    = 7,
  parameter int EVAL_CYC = 1
)(
  input  logic                clk,
  input  logic                rst_n,
  dtc_share_ctrl_if.slave     bus,
  output logic [FEAT_W-1:0]   core_feat,
  input  logic [CLS_W-1:0]    core_cls,
  output logic                busy
);
  localparam int ID_W  = id_width(N_REQ);
  localparam int CNT_W = id_width(EVAL_CYC);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EVAL_CYC - 1);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N_REQ - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [FEAT_W-1:0] core_feat_q, core_feat_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [CLS_W-1:0]  rsp_cls_q, rsp_cls_d;

  logic [N_REQ-1:0]  arb_grant;
  logic [ID_W-1:0]   arb_idx;
  logic              arb_any;
  logic [FEAT_W-1:0] sel_feat;

  dtc_rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .valid     (bus.req_valid),
    .ptr       (ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_valid (arb_any)
  );

  // One-hot mux of the winner's feature slice.
  always_comb begin
    sel_feat = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_grant[i]) sel_feat = bus.req_feat[i*FEAT_W +: FEAT_W];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    core_feat_d = core_feat_q;
    rsp_id_d    = rsp_id_q;
    rsp_cls_d   = rsp_cls_q;
    unique case (state_q)
      S_IDLE: begin
        if (arb_any) begin
          core_feat_d = sel_feat;
          rsp_id_d    = arb_idx;
          ptr_d       = (arb_idx == LAST_ID) ? '0 : arb_idx + 1'b1;
          cnt_d       = CNT_LOAD;
          state_d     = S_EVAL;
        end
      end
      S_EVAL: begin
        // core_cls is only looked at here, once the vector has settled.
        if (cnt_q == '0) begin
          rsp_cls_d = core_cls;
          state_d   = S_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ptr_q       <= '0;
      core_feat_q <= '0;
      rsp_id_q    <= '0;
      rsp_cls_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      core_feat_q <= core_feat_d;
      rsp_id_q    <= rsp_id_d;
      rsp_cls_q   <= rsp_cls_d;
    end
  end

  // The grant is combinational from req_valid; it is also masked by rst_n so
  // no requester sees an accept while the block is held in reset.
  assign bus.req_ready = (state_q == S_IDLE && rst_n) ? arb_grant : '0;
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_cls   = rsp_cls_q;
  assign core_feat     = core_feat_q;
  assign busy          = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dtc_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_dtc_share_ctrl
// Purpose : Self-checking bench for dtc_share_ctrl. dut1 uses EVAL_CYC=1 with
//           a combinational core; dut2 uses EVAL_CYC=3 with a core delayed
//           two cycles.
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
module tb_dtc_share_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  dtc_share_ctrl_if #(.N_REQ(4), .FEAT_W(8), .CLS_W(7)) bus1 ();
  dtc_share_ctrl_if #(.N_REQ(4), .FEAT_W(8), .CLS_W(7)) bus2 ();

  logic [7:0] core_feat1, core_feat2;
  logic [6:0] core_cls1, core_cls2, pipe1, pipe2;
  logic       busy1, busy2;

  assign core_cls1 = core_feat1[6:0] ^ 7'h2A;

  always @(posedge clk) begin
    pipe1 <= core_feat2[6:0] ^ 7'h2A;
    pipe2 <= pipe1;
  end
  assign core_cls2 = pipe2;

  dtc_share_ctrl #(.N_REQ(4), .FEAT_W(8), .CLS_W(7), .EVAL_CYC(1)) dut1 (
    .clk (clk), .rst_n (rst_n), .bus (bus1),
    .core_feat (core_feat1), .core_cls (core_cls1), .busy (busy1)
  );

  dtc_share_ctrl #(.N_REQ(4), .FEAT_W(8), .CLS_W(7), .EVAL_CYC(3)) dut2 (
    .clk (clk), .rst_n (rst_n), .bus (bus2),
    .core_feat (core_feat2), .core_cls (core_cls2), .busy (busy2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string p, input logic [3:0] er, input logic ev,
                      input logic [1:0] eid, input logic [6:0] ecls, input logic eb);
    chk({p, ".req_ready"}, 32'(bus1.req_ready), 32'(er));
    chk({p, ".rsp_valid"}, 32'(bus1.rsp_valid), 32'(ev));
    chk({p, ".rsp_id"},    32'(bus1.rsp_id),    32'(eid));
    chk({p, ".rsp_cls"},   32'(bus1.rsp_cls),   32'(ecls));
    chk({p, ".busy"},      32'(busy1),          32'(eb));
  endtask

  typedef struct {
    logic [3:0]  v;
    logic [31:0] f;
    logic        rr;
    logic [3:0]  er;
    logic        ev;
    logic [1:0]  eid;
    logic [6:0]  ecls;
    logic        eb;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(input logic [3:0] v, input logic [31:0] f, input logic rr,
                              input logic [3:0] er, input logic ev, input logic [1:0] eid,
                              input logic [6:0] ecls, input logic eb);
    vec_t t;
    t.v = v; t.f = f; t.rr = rr; t.er = er; t.ev = ev; t.eid = eid; t.ecls = ecls; t.eb = eb;
    return t;
  endfunction

  // dut2 single transaction: grant check, then count cycles to rsp_valid.
  task automatic run2(input logic [3:0] v, input logic [31:0] f, input logic [3:0] er,
                      input logic [1:0] eid, input logic [6:0] ecls);
    int lat;
    @(negedge clk);
    bus2.req_valid = v; bus2.req_feat = f; bus2.rsp_ready = 1'b1;
    #1;
    chk("e3.req_ready", 32'(bus2.req_ready), 32'(er));
    lat = 0;
    do begin
      @(negedge clk);
      bus2.req_valid = '0;
      #1;
      lat++;
    end while (!bus2.rsp_valid && lat < 12);
    chk("e3.latency", 32'(lat), 32'd4);
    chk("e3.rsp_id",  32'(bus2.rsp_id),  32'(eid));
    chk("e3.rsp_cls", 32'(bus2.rsp_cls), 32'(ecls));
  endtask

  localparam logic [31:0] FALL = 32'h31211101;

  initial begin
    // model state for the randomized phase
    int         m_ptr, m_left, g;
    logic       m_resp;
    logic [1:0] m_id;
    logic [6:0] m_cls;
    logic [7:0] m_feat;
    logic [3:0] rv, eg;
    logic [31:0] rf;
    logic       rr, eb;

    tbl[0]  = mk(4'h0, 32'h0,        1'b1, 4'h0, 1'b0, 2'd0, 7'h00, 1'b0);
    tbl[1]  = mk(4'h1, 32'h0000003C, 1'b1, 4'h1, 1'b0, 2'd0, 7'h00, 1'b0);
    tbl[2]  = mk(4'h0, 32'h0,        1'b1, 4'h0, 1'b0, 2'd0, 7'h00, 1'b1);
    tbl[3]  = mk(4'h0, 32'h0,        1'b1, 4'h0, 1'b1, 2'd0, 7'h16, 1'b1);
    tbl[4]  = mk(4'hF, FALL,         1'b1, 4'h2, 1'b0, 2'd0, 7'h16, 1'b0);
    tbl[5]  = mk(4'hF, FALL,         1'b1, 4'h0, 1'b0, 2'd1, 7'h16, 1'b1);
    for (int i = 6; i <= 10; i++)
      tbl[i] = mk(4'hF, FALL,        1'b0, 4'h0, 1'b1, 2'd1, 7'h3B, 1'b1);
    tbl[11] = mk(4'hF, FALL,         1'b1, 4'h0, 1'b1, 2'd1, 7'h3B, 1'b1);
    tbl[12] = mk(4'hF, FALL,         1'b1, 4'h4, 1'b0, 2'd1, 7'h3B, 1'b0);
    tbl[13] = mk(4'hF, FALL,         1'b1, 4'h0, 1'b0, 2'd2, 7'h3B, 1'b1);
    tbl[14] = mk(4'hF, FALL,         1'b1, 4'h0, 1'b1, 2'd2, 7'h0B, 1'b1);
    tbl[15] = mk(4'hF, FALL,         1'b1, 4'h8, 1'b0, 2'd2, 7'h0B, 1'b0);
    tbl[16] = mk(4'hF, FALL,         1'b1, 4'h0, 1'b0, 2'd3, 7'h0B, 1'b1);
    tbl[17] = mk(4'hF, FALL,         1'b1, 4'h0, 1'b1, 2'd3, 7'h1B, 1'b1);
    tbl[18] = mk(4'hF, FALL,         1'b1, 4'h1, 1'b0, 2'd3, 7'h1B, 1'b0);
    tbl[19] = mk(4'hF, FALL,         1'b1, 4'h0, 1'b0, 2'd0, 7'h1B, 1'b1);
    tbl[20] = mk(4'hF, FALL,         1'b1, 4'h0, 1'b1, 2'd0, 7'h2B, 1'b1);
    tbl[21] = mk(4'h5, FALL,         1'b1, 4'h4, 1'b0, 2'd0, 7'h2B, 1'b0);

    bus1.req_valid = '0; bus1.req_feat = '0; bus1.rsp_ready = 1'b0;
    bus2.req_valid = '0; bus2.req_feat = '0; bus2.rsp_ready = 1'b0;

    // Reset held with random inputs: every output must stay zero.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus1.req_valid = 4'($urandom); bus1.req_feat = $urandom; bus1.rsp_ready = 1'($urandom);
      bus2.req_valid = 4'($urandom); bus2.req_feat = $urandom; bus2.rsp_ready = 1'($urandom);
      #1;
      chk1("rst", 4'h0, 1'b0, 2'd0, 7'h00, 1'b0);
      chk("rst.core_feat", 32'(core_feat1), 32'h0);
      chk("rst.req_ready2", 32'(bus2.req_ready), 32'h0);
      chk("rst.busy2", 32'(busy2), 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus2.req_valid = '0; bus2.req_feat = '0; bus2.rsp_ready = 1'b0;

    // Table-driven vectors: single request, backpressure, round-robin order.
    for (int i = 0; i < 22; i++) begin
      if (i > 0) @(negedge clk);
      bus1.req_valid = tbl[i].v; bus1.req_feat = tbl[i].f; bus1.rsp_ready = tbl[i].rr;
      #1;
      chk1($sformatf("tbl%0d", i), tbl[i].er, tbl[i].ev, tbl[i].eid, tbl[i].ecls, tbl[i].eb);
    end

    // Reset asserted between edges while in EVAL (requester 2 in flight, ptr=3).
    @(negedge clk);
    bus1.req_valid = '0;
    #1;
    chk("midrst.busy_before", 32'(busy1), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk1("midrst", 4'h0, 1'b0, 2'd0, 7'h00, 1'b0);
    chk("midrst.core_feat", 32'(core_feat1), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk("midrst.no_rsp", 32'(bus1.rsp_valid), 32'h0);
      chk("midrst.idle", 32'(busy1), 32'h0);
    end
    @(negedge clk);
    bus1.req_valid = 4'hF; bus1.req_feat = FALL;
    #1;
    chk("midrst.grant0", 32'(bus1.req_ready), 32'h1);

    // Fresh start for the randomized phase.
    @(negedge clk);
    rst_n = 1'b0; bus1.req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0; m_left = 0; m_resp = 1'b0; m_id = 2'd0; m_cls = 7'h00; m_feat = 8'h00;

    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      rv = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom);
      rf = $urandom;
      rr = ($urandom_range(0, 3) != 0);
      bus1.req_valid = rv; bus1.req_feat = rf; bus1.rsp_ready = rr;
      #1;
      eb = (m_left > 0) || m_resp;
      g  = -1;
      eg = 4'h0;
      if (!eb) begin
        for (int k = 0; k < 4; k++)
          if (g < 0 && rv[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
        if (g >= 0) eg[g] = 1'b1;
      end
      chk1("rnd", eg, m_resp, m_id, m_cls, eb);
      chk("rnd.core_feat", 32'(core_feat1), 32'(m_feat));
      if (g >= 0) begin
        m_id   = 2'(g);
        m_feat = rf[g*8 +: 8];
        m_ptr  = (g + 1) % 4;
        m_left = 1;
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_cls  = m_feat[6:0] ^ 7'h2A;
          m_resp = 1'b1;
        end
      end else if (m_resp && rr) begin
        m_resp = 1'b0;
      end
    end
    @(negedge clk);
    bus1.req_valid = '0;

    // EVAL_CYC=3 with a two-cycle-late core.
    run2(4'b0001, 32'h000000FF, 4'b0001, 2'd0, 7'h55);
    run2(4'b0011, 32'h000000FF, 4'b0010, 2'd1, 7'h2A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
